seg_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment scan driver: refreshes DIGITS hex digits, one slot at a time. Per-digit decimal points, PWM brightness control, an inter-digit ghosting guard, and tear-free frame-synchronous value updates. Sits between the integration core (detection counts, status codes) and the board's common-anode display pins.

---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan_driver.sv | 153 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyphs
// (gfedcba bit order), the blank pattern and the largest supported digit count.
package seg_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_GLYPH [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph (gfedcba).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_GLYPH[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with PWM brightness, ghosting guard and
// frame-synchronous value updates. Optional leading-zero blanking: SEG_LZB_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 100000,
  parameter int DUTY_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic [DUTY_W-1:0]     brightness,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VAL_W = 4 * DIGITS;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DUTY_W-1:0] pwm_q, pwm_d;
  logic [VAL_W-1:0]  disp_val_q, disp_val_d, pend_val_q, pend_val_d;
  logic [DIGITS-1:0] disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic              pend_valid_q, pend_valid_d;
  logic              seen_wrap_q, seen_wrap_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              dp_q, dp_d;
  logic              frame_start_q, frame_start_d;

  logic              term_cnt, frame_end, blank;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic [6:0]        glyph;

  seg_hex_decode u_dec (
    .nibble (cur_nib),
    .seg    (glyph)
  );

  always_comb begin
    term_cnt  = (pre_q == PRE_W'(CLK_DIV - 1));
    frame_end = term_cnt && (idx_q == IDX_W'(DIGITS - 1));

    pre_d = term_cnt ? '0 : pre_q + 1'b1;
    idx_d = idx_q;
    if (term_cnt) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    pwm_d = pwm_q + 1'b1;

    // load is a single-cycle strobe with no back-pressure; the last load
    // before a frame boundary is the one that gets displayed.
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
    if (frame_end) begin
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
      end else if (pend_valid_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
      pend_valid_d = 1'b0;
    end
    seen_wrap_d = seen_wrap_q | frame_end;
  end

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib = disp_val_q[i*4 +: 4];
        cur_dp  = disp_dp_q[i];
      end
    end
  end

`ifdef SEG_LZB_EN
  logic [IDX_W-1:0] msnz;
  always_comb begin
    msnz = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (disp_val_q[i*4 +: 4] != 4'h0) msnz = IDX_W'(i);
    end
    blank = (idx_q > msnz);
  end
`else
  assign blank = 1'b0;
`endif

  // Only the anode is PWM-gated; pre == 0 keeps every anode off for one cycle
  // so the previous digit's segments cannot ghost onto the next one.
  always_comb begin
    seg_d         = blank ? SEG_BLANK : glyph;
    dp_d          = ~cur_dp;
    an_d          = '1;
    if ((pwm_q < brightness) && (pre_q != '0)) an_d = ~(DIGITS'(1) << idx_q);
    frame_start_d = seen_wrap_q && (pre_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q         <= '0;
      idx_q         <= '0;
      pwm_q         <= '0;
      disp_val_q    <= '0;
      disp_dp_q     <= '0;
      pend_val_q    <= '0;
      pend_dp_q     <= '0;
      pend_valid_q  <= 1'b0;
      seen_wrap_q   <= 1'b0;
      seg_q         <= SEG_BLANK;
      an_q          <= '1;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      pwm_q         <= pwm_d;
      disp_val_q    <= disp_val_d;
      disp_dp_q     <= disp_dp_d;
      pend_val_q    <= pend_val_d;
      pend_dp_q     <= pend_dp_d;
      pend_valid_q  <= pend_valid_d;
      seen_wrap_q   <= seen_wrap_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (DIGITS=4, CLK_DIV=8, DUTY_W=2).
module tb_seg_scan_driver;

  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 8;
  localparam int DUTY_W  = 2;
  localparam int W       = 13;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [15:0]       value;
  logic [3:0]        dp_in;
  logic              load;
  logic [1:0]        brightness;
  logic [6:0]        seg;
  logic [3:0]        an;
  logic              dp;
  logic              frame_start;

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .DUTY_W(DUTY_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .dp_in       (dp_in),
    .load        (load),
    .brightness  (brightness),
    .seg         (seg),
    .an          (an),
    .dp          (dp),
    .frame_start (frame_start)
  );

  logic [6:0] glyph_tbl [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference state of the scan as it should be before each clock edge.
  int          m_pre, m_idx, m_pwm;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp;
  bit          m_pv, m_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_idx = 0; m_pwm = 0;
    m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0;
    m_pv = 0; m_seen = 0;
    exp_q.delete();
  endtask

  function automatic logic [W-1:0] model_out();
    logic [6:0] g;
    logic [3:0] a;
    int         top;
    g = glyph_tbl[m_disp[m_idx*4 +: 4]];
`ifdef SEG_LZB_EN
    top = 0;
    for (int i = 0; i < 4; i++) if (m_disp[i*4 +: 4] != 4'h0) top = i;
    if (m_idx > top) g = 7'h7F;
`else
    top = 0;
`endif
    a = 4'hF;
    if (m_pwm < int'(brightness) && m_pre != 0) a[m_idx] = 1'b0;
    return {g, a, ~m_ddp[m_idx], (m_seen && m_pre == 0 && m_idx == 0)};
  endfunction

  task automatic model_advance();
    bit fe;
    fe = (m_pre == CLK_DIV - 1) && (m_idx == DIGITS - 1);
    if (load) begin m_pend = value; m_pdp = dp_in; m_pv = 1; end
    if (fe) begin
      if (load) begin m_disp = value; m_ddp = dp_in; end
      else if (m_pv) begin m_disp = m_pend; m_ddp = m_pdp; end
      m_pv = 0;
      m_seen = 1;
    end
    m_pwm = (m_pwm + 1) % 4;
    if (m_pre == CLK_DIV - 1) begin m_pre = 0; m_idx = (m_idx + 1) % DIGITS; end
    else m_pre++;
  endtask

  // One clock: predict the registered outputs, advance, then compare.
  task automatic step();
    logic [W-1:0] e;
    exp_q.push_back(model_out());
    model_advance();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("scan", {seg, an, dp, frame_start}, e);
  endtask

  task automatic step_to(input int pre, input int idx);
    int n = 0;
    while (!(m_pre == pre && m_idx == idx) && n < 80) begin step(); n++; end
  endtask

  task automatic wait_fs(input string tag);
    int n = 0;
    do begin step(); n++; end while (frame_start !== 1'b1 && n < 40);
    chk(tag, frame_start, 1);
  endtask

  logic [6:0] a5c3_exp [0:3] = '{7'h30, 7'h46, 7'h12, 7'h08};
  logic [6:0] lzb_exp  [0:3];

  initial begin
    int cnt;
    logic [6:0] prev_seg;

    rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; brightness = 2'd3;
    model_reset();
    #12;
    chk("rst_seg", seg, 7'h7F);
    chk("rst_an", an, 4'hF);
    chk("rst_dp", dp, 1);
    chk("rst_fs", frame_start, 0);
    rst_n = 1'b1;

    // Idle scan of zeros, then frame period
    repeat (40) step();
    chk("zero_glyph", seg, 7'h40);
    wait_fs("fs_first");
    cnt = 0;
    do begin step(); cnt++; end while (frame_start !== 1'b1 && cnt < 40);
    chk("fs_period", cnt, 32);

    // Mid-frame load is held back until the frame boundary
    step_to(3, 2);
    value = 16'hA5C3; load = 1'b1;
    step();
    load = 1'b0; value = 16'h0000;
    wait_fs("fs_a5c3");
    repeat (3) step();
    for (int d = 0; d < 4; d++) begin
      chk("a5c3_digit", seg, a5c3_exp[d]);
      repeat (8) step();
    end

    // Load on the boundary cycle, then a second load in the same frame
    step_to(CLK_DIV - 1, DIGITS - 1);
    value = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    repeat (3) step();
    chk("bnd_frame_n", seg, 7'h19);
    value = 16'h5678; load = 1'b1;
    step();
    load = 1'b0;
    wait_fs("fs_5678");
    repeat (3) step();
    chk("bnd_frame_n1", seg, 7'h00);

    // Brightness 1: one lit cycle in four, the one at pre==0 suppressed
    brightness = 2'd1;
    step();
    cnt = 0;
    for (int i = 0; i < 32; i++) begin step(); if (an !== 4'hF) cnt++; end
    chk("b1_lit_cycles", cnt, 4);

    brightness = 2'd0;
    step();
    cnt = 0;
    prev_seg = seg;
    for (int i = 0; i < 32; i++) begin
      step();
      if (an !== 4'hF) cnt++;
      if (seg !== prev_seg) cnt += 100;
      prev_seg = seg;
    end
    chk("b0_dark", cnt % 100, 0);
    chk("b0_seg_toggles", (cnt >= 300), 1);
    brightness = 2'd3;

    // Leading-zero case
`ifdef SEG_LZB_EN
    lzb_exp = '{7'h40, 7'h78, 7'h7F, 7'h7F};
`else
    lzb_exp = '{7'h40, 7'h78, 7'h40, 7'h40};
`endif
    value = 16'h0070; dp_in = 4'b1000; load = 1'b1;
    step();
    load = 1'b0;
    wait_fs("fs_lzb");
    repeat (3) step();
    for (int d = 0; d < 4; d++) begin
      chk("lzb_seg", seg, lzb_exp[d]);
      chk("lzb_dp", dp, (d == 3) ? 1'b0 : 1'b1);
      repeat (8) step();
    end

    // Asynchronous reset mid-slot
    step_to(4, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_seg", seg, 7'h7F);
    chk("arst_an", an, 4'hF);
    chk("arst_dp", dp, 1);
    chk("arst_fs", frame_start, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    dp_in = 4'b0000;
    step();
    chk("post_rst_zero", seg, 7'h40);
    repeat (4) step();
    chk("post_rst_idx0", an, 4'hE);
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
